// File: rtl/sub32_serial.sv
// sub32_serial: bit-serial subtractor, out = ina - inb - bi, LSB first.
// One difference bit per clock through a single borrow flop; start/done
// handshake, with the result and flags registered and held until the next done.
module sub32_serial #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] ina,
  input  logic [N-1:0] inb,
  input  logic         bi,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] out,
  output logic         bo,
  output logic         ov,
  output logic         zero
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   r_q, r_d;
  logic           br_q, br_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sa_q, sa_d;
  logic           sb_q, sb_d;
  logic [N-1:0]   out_q, out_d;
  logic           bo_q, bo_d;
  logic           ov_q, ov_d;
  logic           zero_q, zero_d;

  logic           d_bit;
  logic           br_nxt;
  logic [N-1:0]   r_shift;

  // One full-subtractor bit slice on the current LSBs.
  always_comb begin
    d_bit   = a_q[0] ^ b_q[0] ^ br_q;
    br_nxt  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    r_shift = {d_bit, r_q[N-1:1]};
  end

  // Next-state, datapath shifting and result capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    out_d   = out_q;
    bo_d    = bo_q;
    ov_d    = ov_q;
    zero_d  = zero_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = ina;
          b_d     = inb;
          br_d    = bi;
          sa_d    = ina[N-1];
          sb_d    = inb[N-1];
          r_d     = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nxt;
        r_d   = r_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          // The last shifted value is captured directly so the result is
          // visible in the same cycle done is raised.
          state_d = S_DONE;
          out_d   = r_shift;
          bo_d    = br_nxt;
          ov_d    = (sa_q ^ sb_q) & (sa_q ^ r_shift[N-1]);
          zero_d  = (r_shift == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      out_q   <= '0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      out_q   <= out_d;
      bo_q    <= bo_d;
      ov_q    <= ov_d;
      zero_q  <= zero_d;
    end
  end

  // Status decodes and registered result outputs.
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    out  = out_q;
    bo   = bo_q;
    ov   = ov_q;
    zero = zero_q;
  end

endmodule

// File: tb/tb_sub32_serial.sv
// tb_sub32_serial: directed and random checks of the serial subtractor.
module tb_sub32_serial;

  localparam int unsigned N = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] ina;
  logic [N-1:0] inb;
  logic         bi;
  logic         busy;
  logic         done;
  logic [N-1:0] out;
  logic         bo;
  logic         ov;
  logic         zero;

  int checks;
  int errors;

  sub32_serial #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ina   (ina),
    .inb   (inb),
    .bi    (bi),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .bo    (bo),
    .ov    (ov),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present operands with start for one sampling edge; returns #1 after it.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    ina   = a;
    inb   = b;
    bi    = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges after the sampling edge until done is seen (bounded).
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < int'(N) + 10) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
    end
    if (!done) check("done_timeout", 64'(cyc), 64'(N));
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c;
    logic [N-1:0] e_out;
    logic         e_bo;
    logic         e_ov;
    logic         e_zero;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cyc;
    logic [N:0]   model;
    logic [N-1:0] ra, rb;
    logic         rc;
    logic         e_ov;

    checks = 0;
    errors = 0;
    start  = 1'b0;
    ina    = '0;
    inb    = '0;
    bi     = 1'b0;

    vecs[0] = '{32'd5,        32'd3,        1'b0, 32'd2,        1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'd0,        32'd1,        1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h80000000, 32'd1,        1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'd10,       32'd10,       1'b0, 32'd0,        1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'd0,        32'd0,        1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{32'h12345678, 32'h02345678, 1'b0, 32'h10000000, 1'b0, 1'b0, 1'b0};

    // Reset state, then idle with no start.
    rst_n = 1'b0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out",  64'(out),  64'd0);
    check("rst_flags", 64'({bo, ov, zero}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_done", 64'(done), 64'd0);
      check("idle_out",  64'(out),  64'd0);
    end

    // Directed vectors with hand-computed results; done after N edges
    // beyond the sampling edge (N+1 cycles counting the start cycle).
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      issue(vecs[i].a, vecs[i].b, vecs[i].c);
      check("vec_busy", 64'(busy), 64'd1);
      wait_done(cyc);
      check("vec_latency", 64'(cyc), 64'(N));
      check("vec_out",  64'(out),  64'(vecs[i].e_out));
      check("vec_bo",   64'(bo),   64'(vecs[i].e_bo));
      check("vec_ov",   64'(ov),   64'(vecs[i].e_ov));
      check("vec_zero", 64'(zero), 64'(vecs[i].e_zero));
      @(posedge clk);
      #1;
      check("done_pulse", 64'(done), 64'd0);
      check("out_hold",   64'(out),  64'(vecs[i].e_out));
    end

    // Back-to-back: restart in the DONE cycle; old result holds during RUN.
    @(negedge clk);
    issue(32'd10, 32'd10, 1'b0);
    wait_done(cyc);
    check("b2b_first_zero", 64'(zero), 64'd1);
    issue(32'd0, 32'd0, 1'b1);
    check("b2b_busy", 64'(busy), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check("b2b_hold_out",  64'(out),  64'd0);
    check("b2b_hold_zero", 64'(zero), 64'd1);
    wait_done(cyc);
    check("b2b_latency", 64'(cyc), 64'(N - 5));
    check("b2b_out", 64'(out), 64'hFFFFFFFF);
    check("b2b_bo",  64'(bo),  64'd1);
    @(posedge clk);
    #1;

    // start and operand changes while busy are ignored.
    @(negedge clk);
    issue(32'd5, 32'd3, 1'b0);
    ina   = 32'hDEADBEEF;
    inb   = 32'h00000001;
    bi    = 1'b1;
    start = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      ina = ina + 32'd7;
    end
    start = 1'b0;
    wait_done(cyc);
    check("ign_latency", 64'(cyc + 4), 64'(N));
    check("ign_out", 64'(out), 64'd2);
    check("ign_bo",  64'(bo),  64'd0);
    @(posedge clk);
    #1;

    // Random vectors against an N+1-bit reference subtraction.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1, 0));
      if (i % 10 == 0) rb = ra;
      model = {1'b0, ra} - {1'b0, rb} - {{N{1'b0}}, rc};
      e_ov  = (ra[N-1] ^ rb[N-1]) & (ra[N-1] ^ model[N-1]);
      @(negedge clk);
      issue(ra, rb, rc);
      wait_done(cyc);
      check("rnd_result", 64'({bo, out}), 64'(model));
      check("rnd_zero", 64'(zero), 64'(model[N-1:0] == '0));
      if (!rc) check("rnd_ov", 64'(ov), 64'(e_ov));
    end
    @(posedge clk);
    #1;

    // Reset in the middle of RUN aborts with no done.
    @(negedge clk);
    issue(32'd100, 32'd1, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    check("abort_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_out",  64'(out),  64'd0);
    check("abort_flags", 64'({bo, ov, zero}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < int'(N) + 4; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", 64'({busy, done}), 64'd0);
    end

    // Fresh operation after release completes normally.
    @(negedge clk);
    issue(32'd100, 32'd1, 1'b0);
    wait_done(cyc);
    check("post_latency", 64'(cyc), 64'(N));
    check("post_out", 64'(out), 64'd99);
    check("post_bo",  64'(bo),  64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
